// File: rtl/popcount_sched.sv
// popcount_sched: round-robin grant of one shared bit-serial ones-counter across NREQ requesters
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   i_req          per-requester level request
//   i_data         per-requester word, requester i at [i*WIDTH +: WIDTH]
//   o_gnt          one-hot grant pulse, high for the cycle after the grant edge
//   o_busy         high whenever a job is in flight or its result is pending
//   o_res_valid    result available, held until accepted
//   o_res_id       requester owning the result
//   o_res_count    ones count of the captured word
//   i_res_ready    result consumer accepts
module popcount_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH + 1),
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_data,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_busy,
    output logic                    o_res_valid,
    output logic [IDW-1:0]          o_res_id,
    output logic [CNTW-1:0]         o_res_count,
    input  logic                    i_res_ready
);
    localparam int BW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;
    state_t            r_state, w_next;
    logic [NREQ-1:0]   r_gnt;
    logic              r_res_valid;
    logic [IDW-1:0]    r_res_id, r_last, w_win, w_j;
    logic [CNTW-1:0]   r_res_count;
    logic [BW-1:0]     r_idx;
    logic [WIDTH-1:0]  r_word;
    logic              w_found, w_last_bit;
    // Search downward from the farthest candidate so the nearest one after r_last wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = IDW'((int'(r_last) + k) % NREQ);
            if (i_req[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end
    assign w_last_bit = r_idx == BW'(WIDTH - 1);
    always_comb begin
        w_next = r_state == S_IDLE  ? (w_found ? S_COUNT : S_IDLE) :
                 r_state == S_COUNT ? (w_last_bit ? S_DONE : S_COUNT) :
                                      (i_res_ready ? S_IDLE : S_DONE);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_count <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_last      <= IDW'(NREQ - 1);
        end else begin
            r_state <= w_next;
            r_gnt   <= '0;
            if (r_state == S_IDLE && w_found) begin
                r_gnt       <= NREQ'(1) << w_win;
                r_word      <= i_data[w_win*WIDTH +: WIDTH];
                r_res_id    <= w_win;
                r_last      <= w_win;
                r_res_count <= '0;
                r_idx       <= '0;
            end
            if (r_state == S_COUNT) begin
                r_res_count <= r_res_count + CNTW'(r_word[r_idx]);
                r_idx       <= r_idx + BW'(1);
                r_res_valid <= w_last_bit;
            end
            if (r_state == S_DONE && i_res_ready)
                r_res_valid <= 1'b0;
        end
    end
    assign o_gnt       = r_gnt;
    assign o_busy      = r_state != S_IDLE;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_count = r_res_count;
endmodule

// File: tb/tb_popcount_sched.sv
// tb_popcount_sched: directed self-checking bench for popcount_sched
module tb_popcount_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  i_req = '0;
    logic [63:0] i_data = '0;
    logic [3:0]  o_gnt;
    logic        o_busy, o_res_valid;
    logic [1:0]  o_res_id;
    logic [4:0]  o_res_count;
    logic        i_res_ready = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int n;
    logic [15:0] pats [4] = '{16'h0000, 16'h8001, 16'hA5A5, 16'h0001};
    logic [4:0]  pcnt [4] = '{5'd0, 5'd2, 5'd8, 5'd1};

    popcount_sched dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt), .o_busy(o_busy), .o_res_valid(o_res_valid),
        .o_res_id(o_res_id), .o_res_count(o_res_count), .i_res_ready(i_res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt();
        int c = 0;
        @(negedge clk);
        while (o_gnt == 4'b0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("gnt_timeout", 32'(c < 40), 32'd1);
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!o_res_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("valid_timeout", 32'(c < 40), 32'd1);
    endtask

    task automatic job(input logic [3:0] g, input logic [3:0] req_after, input logic [4:0] cnt, input logic [1:0] id);
        int c;
        wait_gnt();
        check("gnt", 32'(o_gnt), 32'(g));
        i_req = req_after;
        wait_valid(c);
        check("latency", 32'(c), 32'd16);
        check("count", 32'(o_res_count), 32'(cnt));
        check("id", 32'(o_res_id), 32'(id));
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_gnt", 32'(o_gnt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_res_valid), 32'd0);
        check("rst_id", 32'(o_res_id), 32'd0);
        check("rst_count", 32'(o_res_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // single requester, all ones
        i_data[15:0] = 16'hFFFF;
        i_req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 32'(o_gnt), 32'b0001);
        check("t1_busy", 32'(o_busy), 32'd1);
        i_req = 4'b0000;
        @(negedge clk);
        check("t1_gnt_pulse", 32'(o_gnt), 32'd0);
        wait_valid(n);
        check("t1_latency", 32'(n), 32'd15);
        check("t1_count", 32'(o_res_count), 32'd16);
        check("t1_id", 32'(o_res_id), 32'd0);
        @(negedge clk);
        check("t1_valid_drop", 32'(o_res_valid), 32'd0);
        check("t1_busy_drop", 32'(o_busy), 32'd0);
        check("t1_hold_count", 32'(o_res_count), 32'd16);
        // patterns on requester 2
        for (int p = 0; p < 4; p++) begin
            i_data[47:32] = pats[p];
            i_req = 4'b0100;
            job(4'b0100, 4'b0000, pcnt[p], 2'd2);
            @(negedge clk);
            check("t2_one_handshake", 32'(o_res_valid), 32'd0);
        end
        // fairness from a fresh pointer
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_data = {16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        i_req = 4'b1111;
        job(4'b0001, 4'b1111, 5'd4, 2'd0);
        job(4'b0010, 4'b1111, 5'd8, 2'd1);
        job(4'b0100, 4'b1111, 5'd12, 2'd2);
        job(4'b1000, 4'b1111, 5'd16, 2'd3);
        job(4'b0001, 4'b1111, 5'd4, 2'd0);
        // requesters that drop after grant are skipped
        job(4'b0010, 4'b1001, 5'd8, 2'd1);
        job(4'b1000, 4'b0001, 5'd16, 2'd3);
        job(4'b0001, 4'b0000, 5'd4, 2'd0);
        // backpressure with other requests pending
        @(negedge clk);
        i_res_ready = 1'b0;
        i_data[31:16] = 16'h0F0F;
        i_data[47:32] = 16'h0007;
        i_req = 4'b1111;
        job(4'b0010, 4'b1101, 5'd8, 2'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(o_res_valid), 32'd1);
            check("bp_count", 32'(o_res_count), 32'd8);
            check("bp_id", 32'(o_res_id), 32'd1);
            check("bp_gnt", 32'(o_gnt), 32'd0);
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(o_res_valid), 32'd0);
        check("bp_gnt_accept", 32'(o_gnt), 32'd0);
        @(negedge clk);
        check("bp_next_gnt", 32'(o_gnt), 32'b0100);
        i_req = 4'b0000;
        wait_valid(n);
        check("bp_next_count", 32'(o_res_count), 32'd3);
        check("bp_next_id", 32'(o_res_id), 32'd2);
        // inputs changed mid-job
        @(negedge clk);
        i_data[15:0] = 16'h1234;
        i_req = 4'b0001;
        wait_gnt();
        check("mid_gnt", 32'(o_gnt), 32'b0001);
        i_req = 4'b0000;
        repeat (3) @(negedge clk);
        i_data[15:0] = 16'hFFFF;
        wait_valid(n);
        check("mid_count", 32'(o_res_count), 32'd5);
        check("mid_id", 32'(o_res_id), 32'd0);
        // reset after 8 bits
        @(negedge clk);
        i_data[31:16] = 16'h00FF;
        i_req = 4'b0001;
        wait_gnt();
        check("rm_gnt", 32'(o_gnt), 32'b0001);
        i_req = 4'b0000;
        repeat (8) @(negedge clk);
        check("rm_partial", 32'(o_res_count), 32'd8);
        check("rm_busy", 32'(o_busy), 32'd1);
        #2 reset = 1'b1;
        i_req = 4'b0011;
        #1;
        check("rm_busy_rst", 32'(o_busy), 32'd0);
        check("rm_valid_rst", 32'(o_res_valid), 32'd0);
        check("rm_count_rst", 32'(o_res_count), 32'd0);
        check("rm_id_rst", 32'(o_res_id), 32'd0);
        check("rm_gnt_rst", 32'(o_gnt), 32'd0);
        @(negedge clk);
        check("rm_valid_hold", 32'(o_res_valid), 32'd0);
        reset = 1'b0;
        job(4'b0001, 4'b0010, 5'd16, 2'd0);
        job(4'b0010, 4'b0000, 5'd8, 2'd1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
